// File: rtl/serial_tx_fifo.sv
// Byte FIFO feeding a UART transmitter through its sbyte/send/busy handshake.
// Optional dropped-write counter port ovf_cnt is enabled by SERIAL_TXF_OVF_CNT_EN.
module serial_tx_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk100,
  input  logic                  reset,
  input  logic [7:0]            wr_data,
  input  logic                  wr_en,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level,
  output logic [7:0]            sbyte,
  output logic                  send,
  input  logic                  busy
`ifdef SERIAL_TXF_OVF_CNT_EN
  ,
  output logic [7:0]            ovf_cnt
`endif
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PTR_INC = {{DEPTH_LOG2{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_BUSY,
    WAIT_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2:0]   wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0]   rd_ptr_q, rd_ptr_d;
  logic [7:0]            sbyte_q, sbyte_d;
  logic                  send_q, send_d;
  logic                  wr_accept;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                 (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
  assign level = wr_ptr_q - rd_ptr_q;
  assign sbyte = sbyte_q;
  assign send  = send_q;

  assign wr_accept = wr_en && !full;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + PTR_INC;
    end
  end

  // The byte is latched into sbyte on entering SEND, but the read pointer only
  // advances on leaving SEND, so occupancy drops one cycle after the send pulse.
  always_comb begin
    state_d  = state_q;
    send_d   = 1'b0;
    sbyte_d  = sbyte_q;
    rd_ptr_d = rd_ptr_q;
    unique case (state_q)
      IDLE: begin
        if (!empty && !busy) begin
          sbyte_d = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
          send_d  = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        rd_ptr_d = rd_ptr_q + PTR_INC;
        state_d  = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (busy) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!busy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk100 or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      sbyte_q  <= '0;
      send_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      sbyte_q  <= sbyte_d;
      send_q   <= send_d;
    end
  end

  // Storage needs no reset: the pointers alone define which entries are valid.
  always_ff @(posedge clk100) begin
    if (wr_accept) begin
      mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= wr_data;
    end
  end

`ifdef SERIAL_TXF_OVF_CNT_EN
  logic [7:0] ovf_cnt_q, ovf_cnt_d;

  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (wr_en && full && (ovf_cnt_q != '1)) begin
      ovf_cnt_d = ovf_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk100 or posedge reset) begin
    if (reset) begin
      ovf_cnt_q <= '0;
    end else begin
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  assign ovf_cnt = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_serial_tx_fifo.sv
// Directed bench for serial_tx_fifo with a simple transmitter busy model and
// an in-order scoreboard of expected sent bytes.
`timescale 1ns/1ps

`define CHK(TAG, OBS, EXP) \
  begin \
    vec_cnt++; \
    assert ((OBS) === (EXP)) else begin \
      miscmp++; \
      $error("FAIL %s observed=%0h expected=%0h", TAG, OBS, EXP); \
    end \
  end

module tb_serial_tx_fifo;

  localparam int TXLEN = 4;

  logic       clk100 = 1'b0;
  logic       reset;
  logic [7:0] wr_data;
  logic       wr_en;
  logic       full;
  logic       empty;
  logic [4:0] level;
  logic [7:0] sbyte;
  logic       send;
  logic       busy;
`ifdef SERIAL_TXF_OVF_CNT_EN
  logic [7:0] ovf_cnt;
`endif

  int         vec_cnt = 0;
  int         miscmp  = 0;
  int         send_cnt = 0;
  int         tx_left = 0;
  int         level_max = 0;
  logic       start_pending = 1'b0;
  logic       busy_force = 1'b0;
  logic       prev_send = 1'b0;
  logic [7:0] exp_b;
  logic [7:0] exp_q [$];

  serial_tx_fifo #(.DEPTH_LOG2(4)) dut (
    .clk100  (clk100),
    .reset   (reset),
    .wr_data (wr_data),
    .wr_en   (wr_en),
    .full    (full),
    .empty   (empty),
    .level   (level),
    .sbyte   (sbyte),
    .send    (send),
    .busy    (busy)
`ifdef SERIAL_TXF_OVF_CNT_EN
    ,
    .ovf_cnt (ovf_cnt)
`endif
  );

  always #5 clk100 = ~clk100;

  // Advance one cycle; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk100);
    #1;
    if (send) begin
      send_cnt++;
      `CHK("send_one_cycle", prev_send, 1'b0)
      `CHK("send_busy_low_before", busy, 1'b0)
      vec_cnt++;
      assert (exp_q.size() != 0) else begin
        miscmp++;
        $error("FAIL unexpected_send observed=%0h expected=none", sbyte);
      end
      if (exp_q.size() != 0) begin
        exp_b = exp_q.pop_front();
        `CHK("sbyte_order", sbyte, exp_b)
      end
    end
    if (tx_left > 0) tx_left--;
    if (start_pending) begin
      tx_left       = TXLEN;
      start_pending = 1'b0;
    end
    if (send) start_pending = 1'b1;
    busy      = busy_force || (tx_left > 0);
    prev_send = send;
    if (int'(level) > level_max) level_max = int'(level);
  endtask

  task automatic write_byte(input logic [7:0] d);
    wr_data = d;
    wr_en   = 1'b1;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic drain(input int max_cycles, input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy || start_pending || !empty) && n < max_cycles) begin
      tick();
      n++;
    end
    `CHK(tag, (n < max_cycles), 1'b1)
    repeat (3) tick();
  endtask

  initial begin
    reset   = 1'b1;
    wr_data = '0;
    wr_en   = 1'b0;
    busy    = 1'b0;

    // Reset state
    tick();
    tick();
    `CHK("rst_send", send, 1'b0)
    `CHK("rst_sbyte", sbyte, 8'h00)
    `CHK("rst_full", full, 1'b0)
    `CHK("rst_empty", empty, 1'b1)
    `CHK("rst_level", level, 5'd0)
`ifdef SERIAL_TXF_OVF_CNT_EN
    `CHK("rst_ovf_cnt", ovf_cnt, 8'h00)
`endif
    reset = 1'b0;
    tick();

    // Single byte latency: write in N
    exp_q.push_back(8'h55);
    send_cnt = 0;
    wr_data  = 8'h55;
    wr_en    = 1'b1;
    tick();
    wr_en = 1'b0;
    `CHK("single_n1_empty", empty, 1'b0)
    `CHK("single_n1_level", level, 5'd1)
    `CHK("single_n1_send", send, 1'b0)
    tick();
    `CHK("single_n2_send", send, 1'b1)
    `CHK("single_n2_sbyte", sbyte, 8'h55)
    `CHK("single_n2_level", level, 5'd1)
    tick();
    `CHK("single_n3_send", send, 1'b0)
    `CHK("single_n3_empty", empty, 1'b1)
    `CHK("single_n3_level", level, 5'd0)
    drain(100, "single_drain_timeout");
    `CHK("single_sbyte_hold", sbyte, 8'h55)
    `CHK("single_send_count", send_cnt, 1)

    // Burst of 16 with transmitter held busy, then two overflow writes
    busy_force = 1'b1;
    busy       = 1'b1;
    send_cnt   = 0;
    for (int i = 1; i <= 16; i++) begin
      exp_q.push_back(8'(i));
      write_byte(8'(i));
    end
    `CHK("burst_full", full, 1'b1)
    `CHK("burst_level", level, 5'd16)
    `CHK("burst_empty", empty, 1'b0)
    write_byte(8'hAA);
    write_byte(8'hBB);
    `CHK("ovf_level", level, 5'd16)
    `CHK("ovf_full", full, 1'b1)
    `CHK("ovf_no_send", send_cnt, 0)
`ifdef SERIAL_TXF_OVF_CNT_EN
    `CHK("ovf_cnt", ovf_cnt, 8'h02)
`endif
    busy_force = 1'b0;
    busy       = 1'b0;
    drain(400, "burst_drain_timeout");
    `CHK("burst_send_count", send_cnt, 16)
    `CHK("burst_end_empty", empty, 1'b1)
    `CHK("burst_end_level", level, 5'd0)

    // Write lands in the same cycle as a pop with level 3
    busy_force = 1'b1;
    busy       = 1'b1;
    send_cnt   = 0;
    exp_q.push_back(8'hA1);
    exp_q.push_back(8'hA2);
    exp_q.push_back(8'hA3);
    exp_q.push_back(8'hA4);
    write_byte(8'hA1);
    write_byte(8'hA2);
    write_byte(8'hA3);
    `CHK("simul_pre_level", level, 5'd3)
    busy_force = 1'b0;
    busy       = 1'b0;
    tick();
    `CHK("simul_send", send, 1'b1)
    write_byte(8'hA4);
    `CHK("simul_level", level, 5'd3)
    drain(200, "simul_drain_timeout");
    `CHK("simul_send_count", send_cnt, 4)
    `CHK("simul_end_empty", empty, 1'b1)

    // 40 single-byte transfers across pointer rollover
    send_cnt  = 0;
    level_max = 0;
    for (int k = 0; k < 40; k++) begin
      exp_q.push_back(8'(8'h20 + k));
      write_byte(8'(8'h20 + k));
      drain(50, "wrap_drain_timeout");
    end
    `CHK("wrap_send_count", send_cnt, 40)
    `CHK("wrap_level_max", level_max, 1)
    `CHK("wrap_end_empty", empty, 1'b1)

    // Reset one cycle after a send with 5 bytes still queued
    busy_force = 1'b1;
    busy       = 1'b1;
    for (int j = 0; j < 6; j++) begin
      exp_q.push_back(8'(8'hC1 + j));
      write_byte(8'(8'hC1 + j));
    end
    busy_force = 1'b0;
    busy       = 1'b0;
    tick();
    `CHK("rstmid_send", send, 1'b1)
    tick();
    `CHK("rstmid_level", level, 5'd5)
    reset = 1'b1;
    #1;
    `CHK("rstmid_send_low", send, 1'b0)
    `CHK("rstmid_sbyte", sbyte, 8'h00)
    `CHK("rstmid_empty", empty, 1'b1)
    `CHK("rstmid_level0", level, 5'd0)
    `CHK("rstmid_full", full, 1'b0)
`ifdef SERIAL_TXF_OVF_CNT_EN
    `CHK("rstmid_ovf_cnt", ovf_cnt, 8'h00)
`endif
    exp_q.delete();
    tx_left       = 0;
    start_pending = 1'b0;
    busy          = 1'b0;
    tick();
    tick();
    reset    = 1'b0;
    send_cnt = 0;
    repeat (20) tick();
    `CHK("rstmid_no_send", send_cnt, 0)
    `CHK("rstmid_idle_empty", empty, 1'b1)
    exp_q.push_back(8'h3C);
    write_byte(8'h3C);
    drain(100, "rstmid_drain_timeout");
    `CHK("rstmid_recover_count", send_cnt, 1)
    `CHK("rstmid_recover_sbyte", sbyte, 8'h3C)

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
    $finish;
  end

endmodule
